// File: rtl/brew_uart_pkg.sv
// Shared definitions for the UART transmit path.
//   UART_DATA_W          byte width on request and TX lanes
//   DEFAULT_TIMEOUT_CYC  cycles a granted requester may sit with req_valid low before abort
//   arb_state_e          arbiter FSM encoding (ARB_IDLE, ARB_XFER)
package brew_uart_pkg;

  localparam int UART_DATA_W         = 8;
  localparam int DEFAULT_TIMEOUT_CYC = 1024;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req      request vector, one bit per requester
//   ptr      index of the most recent winner; scanning starts at ptr+1
//   winner   one-hot first requester found scanning ptr+1, ptr+2, ... (mod NUM_REQ)
//   any_req  at least one request bit set
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               any_req
);

  // One extra bit so ptr+off never overflows before the modulo fold.
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(off);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, per-message arbiter sharing one UART TX serializer among NUM_REQ producers.
//   clk, rst   system clock; synchronous active-high reset
//   req_valid  per-requester byte valid
//   req_data   flattened bytes, requester i at [i*DATA_W +: DATA_W]
//   req_last   byte is the final byte of its message
//   req_ready  byte accepted this cycle when paired with req_valid
//   tx_valid   byte offered to the UART TX
//   tx_data    byte to the UART TX (0 when idle)
//   tx_ready   UART TX can accept a byte
//   grant      one-hot current owner, 0 when idle
//   busy       message in progress (state is ARB_XFER)
//   abort      one-cycle pulse when the watchdog revokes a grant
//
// Handshake: a byte moves on every rising edge where valid and ready are both high on the
// same lane. Neither side may make valid depend on ready; the arbiter stores no data, so
// the granted requester's valid/data/last pass straight through to the TX lane and tx_ready
// passes straight back as that requester's req_ready.
module uart_tx_arbiter
  import brew_uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = UART_DATA_W,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_valid,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      abort
);

  localparam int                PTR_W    = $clog2(NUM_REQ);
  localparam int                CNT_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0]  WD_LIMIT = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [PTR_W-1:0]  PTR_RST  = PTR_W'(NUM_REQ - 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    wd_q, wd_d;
  logic                abort_q, abort_d;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic                pick_any;
  logic [PTR_W-1:0]    pick_idx;
  logic                cur_valid;
  logic                cur_last;
  logic                fire;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req     (req_valid),
    .ptr     (ptr_q),
    .winner  (pick_onehot),
    .any_req (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) pick_idx = PTR_W'(i);
    end
  end

  // While in XFER the pointer always equals the granted index, so it doubles as the mux select.
  assign busy      = (state_q == ARB_XFER);
  assign grant     = grant_q;
  assign abort     = abort_q;
  assign cur_valid = req_valid[ptr_q];
  assign cur_last  = req_last[ptr_q];
  assign tx_valid  = busy & cur_valid;
  assign tx_data   = busy ? req_data[int'(ptr_q)*DATA_W +: DATA_W] : '0;
  assign fire      = tx_valid & tx_ready;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = busy & tx_ready & (ptr_q == PTR_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    abort_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        wd_d = '0;
        if (pick_any) begin
          grant_d = pick_onehot;
          ptr_d   = pick_idx;
          state_d = ARB_XFER;
        end
      end
      ARB_XFER: begin
        if (fire && cur_last) begin
          grant_d = '0;
          wd_d    = '0;
          state_d = ARB_IDLE;
        end else if (cur_valid) begin
          // A valid byte waiting on tx_ready is backpressure, not a stall.
          wd_d = '0;
        end else if (wd_q == WD_LIMIT) begin
          // Pointer is left at the offender so it goes to the back of the rotation.
          abort_d = 1'b1;
          grant_d = '0;
          wd_d    = '0;
          state_d = ARB_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        wd_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
      wd_q    <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      abort_q <= abort_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [W-1:0]   tx_data;
  logic           tx_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic           abort;

  int tests_run    = 0;
  int tests_failed = 0;

  // Per-requester message streams and the scoreboard of expected transfers ({id, byte}).
  logic [W-1:0]  prod_data[N][$];
  logic          prod_last[N][$];
  logic [10:0]   exp_q[$];
  logic          exp_last_q[$];
  logic [10:0]   obs_q[$];
  int            obs_cyc_q[$];
  int            hs_err;

  uart_tx_arbiter #(
    .NUM_REQ     (N),
    .DATA_W      (W),
    .TIMEOUT_CYC (1024)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant     (grant),
    .busy      (busy),
    .abort     (abort)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached, want completion");
    $fatal(1, "time limit");
  end

  task automatic drive_idle();
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive_idle();
    tx_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int id, input logic v, input logic [W-1:0] d, input logic l);
    req_valid[id]       = v;
    req_data[id*W +: W] = d;
    req_last[id]        = l;
  endtask

  task automatic clear_streams();
    for (int i = 0; i < N; i++) begin
      prod_data[i].delete();
      prod_last[i].delete();
    end
    exp_q.delete();
    exp_last_q.delete();
    obs_q.delete();
    obs_cyc_q.delete();
    hs_err = 0;
  endtask

  task automatic load_byte(input int id, input logic [W-1:0] d, input logic l);
    prod_data[id].push_back(d);
    prod_last[id].push_back(l);
  endtask

  task automatic push_exp(input int id, input logic [W-1:0] d, input logic l);
    exp_q.push_back({3'(id), d});
    exp_last_q.push_back(l);
  endtask

  // Each producer keeps presenting its queue head; a byte is consumed when its own
  // req_valid & req_ready are high at the sampling point.
  task automatic run_traffic(input int max_cyc);
    logic all_empty;
    int   pops;
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clk); #1;
      all_empty = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (prod_data[i].size() > 0) begin
          drive_req(i, 1'b1, prod_data[i][0], prod_last[i][0]);
          all_empty = 1'b0;
        end else begin
          drive_req(i, 1'b0, '0, 1'b0);
        end
      end
      if (all_empty) break;
      @(negedge clk);
      pops = 0;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          pops++;
          obs_q.push_back({3'(i), tx_data});
          obs_cyc_q.push_back(c);
          void'(prod_data[i].pop_front());
          void'(prod_last[i].pop_front());
        end
      end
      if (pops > 1) hs_err++;
      if ((pops == 1) != (tx_valid && tx_ready)) hs_err++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive_idle();
    req_valid = 4'b1111;
    tx_ready  = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if ({grant, busy, abort, tx_valid, req_ready, tx_data} !== {4'b0, 1'b0, 1'b0, 1'b0, 4'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got grant=%b busy=%b abort=%b tx_valid=%b req_ready=%b tx_data=%h want all zero",
               grant, busy, abort, tx_valid, req_ready, tx_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
  endtask

  task automatic test_single_msg();
    apply_reset();
    drive_req(0, 1'b1, 8'h41, 1'b0);
    @(negedge clk);
    tests_run++;
    if ({grant, busy, tx_valid} !== {4'b0000, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL single_idle_cycle: got grant=%b busy=%b tx_valid=%b want 0000 0 0", grant, busy, tx_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if ({grant, busy, tx_valid, tx_data, req_ready} !== {4'b0001, 1'b1, 1'b1, 8'h41, 4'b0001}) begin
      tests_failed++;
      $display("FAIL single_byte0: got grant=%b busy=%b tx_valid=%b tx_data=%h req_ready=%b want 0001 1 1 41 0001",
               grant, busy, tx_valid, tx_data, req_ready);
    end
    @(posedge clk); #1;
    drive_req(0, 1'b1, 8'h42, 1'b0);
    @(negedge clk);
    tests_run++;
    if ({tx_valid, tx_data, req_ready} !== {1'b1, 8'h42, 4'b0001}) begin
      tests_failed++;
      $display("FAIL single_byte1: got tx_valid=%b tx_data=%h req_ready=%b want 1 42 0001", tx_valid, tx_data, req_ready);
    end
    @(posedge clk); #1;
    drive_req(0, 1'b1, 8'h43, 1'b1);
    @(negedge clk);
    tests_run++;
    if ({tx_valid, tx_data, req_ready} !== {1'b1, 8'h43, 4'b0001}) begin
      tests_failed++;
      $display("FAIL single_byte2: got tx_valid=%b tx_data=%h req_ready=%b want 1 43 0001", tx_valid, tx_data, req_ready);
    end
    @(posedge clk); #1;
    drive_req(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    tests_run++;
    if ({grant, busy, tx_valid, tx_data} !== {4'b0000, 1'b0, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL single_release: got grant=%b busy=%b tx_valid=%b tx_data=%h want 0000 0 0 00",
               grant, busy, tx_valid, tx_data);
    end
  endtask

  // Shared scoreboard comparison for traffic scenarios: order, contiguity, idle gap, latency.
  task automatic test_two_req();
    apply_reset();
    clear_streams();
    load_byte(0, 8'hA0, 1'b0); load_byte(0, 8'hA1, 1'b1);
    load_byte(0, 8'hB0, 1'b0); load_byte(0, 8'hB1, 1'b1);
    load_byte(2, 8'hC0, 1'b0); load_byte(2, 8'hC1, 1'b1);
    load_byte(2, 8'hD0, 1'b0); load_byte(2, 8'hD1, 1'b1);
    push_exp(0, 8'hA0, 1'b0); push_exp(0, 8'hA1, 1'b1);
    push_exp(2, 8'hC0, 1'b0); push_exp(2, 8'hC1, 1'b1);
    push_exp(0, 8'hB0, 1'b0); push_exp(0, 8'hB1, 1'b1);
    push_exp(2, 8'hD0, 1'b0); push_exp(2, 8'hD1, 1'b1);
    run_traffic(40);
    tests_run++;
    if (obs_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL two_req_count: got %0d transfers want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests_run++;
      if (obs_q[k] !== exp_q[k]) begin
        tests_failed++;
        $display("FAIL two_req_order[%0d]: got id=%0d data=%h want id=%0d data=%h",
                 k, obs_q[k][10:8], obs_q[k][7:0], exp_q[k][10:8], exp_q[k][7:0]);
      end
      if (k > 0) begin
        tests_run++;
        if (obs_cyc_q[k] - obs_cyc_q[k-1] !== (exp_last_q[k-1] ? 2 : 1)) begin
          tests_failed++;
          $display("FAIL two_req_gap[%0d]: got %0d cycles want %0d",
                   k, obs_cyc_q[k] - obs_cyc_q[k-1], exp_last_q[k-1] ? 2 : 1);
        end
      end
    end
    tests_run++;
    if (obs_cyc_q.size() == 0 || obs_cyc_q[0] !== 1) begin
      tests_failed++;
      $display("FAIL two_req_latency: got first transfer at cycle %0d want 1",
               obs_cyc_q.size() == 0 ? -1 : obs_cyc_q[0]);
    end
    tests_run++;
    if (hs_err !== 0) begin
      tests_failed++;
      $display("FAIL two_req_handshake: got %0d inconsistent cycles want 0", hs_err);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    apply_reset();
    tx_ready = 1'b0;
    drive_req(1, 1'b1, 8'h55, 1'b0);
    @(negedge clk);
    bad = 0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if ({abort, grant, tx_valid, tx_data, req_ready} !== {1'b0, 4'b0010, 1'b1, 8'h55, 4'b0000}) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL stall_hold: got %0d bad cycles of 5000 want 0", bad);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({grant, tx_data, req_ready} !== {4'b0010, 8'h55, 4'b0010}) begin
      tests_failed++;
      $display("FAIL stall_resume: got grant=%b tx_data=%h req_ready=%b want 0010 55 0010", grant, tx_data, req_ready);
    end
    @(posedge clk); #1;
    drive_req(1, 1'b1, 8'h56, 1'b1);
    @(negedge clk);
    tests_run++;
    if ({tx_valid, tx_data, req_ready} !== {1'b1, 8'h56, 4'b0010}) begin
      tests_failed++;
      $display("FAIL stall_last: got tx_valid=%b tx_data=%h req_ready=%b want 1 56 0010", tx_valid, tx_data, req_ready);
    end
    @(posedge clk); #1;
    drive_req(1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    tests_run++;
    if ({grant, busy, abort} !== {4'b0000, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL stall_done: got grant=%b busy=%b abort=%b want 0000 0 0", grant, busy, abort);
    end
  endtask

  task automatic test_watchdog();
    int bad;
    int abort_cnt;
    apply_reset();
    drive_req(3, 1'b1, 8'h77, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    drive_req(0, 1'b1, 8'h10, 1'b1);
    @(negedge clk);
    tests_run++;
    if ({grant, tx_data, req_ready} !== {4'b1000, 8'h77, 4'b1000}) begin
      tests_failed++;
      $display("FAIL wd_first_byte: got grant=%b tx_data=%h req_ready=%b want 1000 77 1000", grant, tx_data, req_ready);
    end
    bad = 0;
    abort_cnt = 0;
    for (int k = 1; k <= 1024; k++) begin
      @(posedge clk); #1;
      drive_req(3, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      if (abort) abort_cnt++;
      if ({grant, busy, tx_valid} !== {4'b1000, 1'b1, 1'b0}) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL wd_hold: got %0d bad cycles in 1024 idle cycles want 0", bad);
    end
    @(posedge clk); #1;
    @(negedge clk);
    if (abort) abort_cnt++;
    tests_run++;
    if ({abort, grant, busy, tx_valid} !== {1'b1, 4'b0000, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL wd_abort: got abort=%b grant=%b busy=%b tx_valid=%b want 1 0000 0 0", abort, grant, busy, tx_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    if (abort) abort_cnt++;
    tests_run++;
    if ({grant, tx_data, req_ready} !== {4'b0001, 8'h10, 4'b0001}) begin
      tests_failed++;
      $display("FAIL wd_next_grant: got grant=%b tx_data=%h req_ready=%b want 0001 10 0001", grant, tx_data, req_ready);
    end
    @(posedge clk); #1;
    drive_req(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    if (abort) abort_cnt++;
    tests_run++;
    if (abort_cnt !== 1) begin
      tests_failed++;
      $display("FAIL wd_abort_count: got %0d abort pulses want 1", abort_cnt);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    drive_req(1, 1'b1, 8'h21, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if ({grant, tx_data} !== {4'b0010, 8'h21}) begin
      tests_failed++;
      $display("FAIL rst_byte0: got grant=%b tx_data=%h want 0010 21", grant, tx_data);
    end
    @(posedge clk); #1;
    drive_req(1, 1'b1, 8'h22, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    drive_req(0, 1'b1, 8'h30, 1'b1);
    @(negedge clk);
    tests_run++;
    if ({grant, tx_valid, busy, req_ready, tx_data, abort} !== {4'b0, 1'b0, 1'b0, 4'b0, 8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL rst_mid_msg: got grant=%b tx_valid=%b busy=%b req_ready=%b tx_data=%h abort=%b want all zero",
               grant, tx_valid, busy, req_ready, tx_data, abort);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++;
    if ({grant, tx_data} !== {4'b0001, 8'h30}) begin
      tests_failed++;
      $display("FAIL rst_rearb: got grant=%b tx_data=%h want 0001 30", grant, tx_data);
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_all_four();
    apply_reset();
    clear_streams();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin
        load_byte(i, 8'(8'h60 + 8'h10 * r + i), 1'b1);
        push_exp(i, 8'(8'h60 + 8'h10 * r + i), 1'b1);
      end
    end
    run_traffic(40);
    tests_run++;
    if (obs_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL all_four_count: got %0d transfers want %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests_run++;
      if (obs_q[k] !== exp_q[k]) begin
        tests_failed++;
        $display("FAIL all_four_order[%0d]: got id=%0d data=%h want id=%0d data=%h",
                 k, obs_q[k][10:8], obs_q[k][7:0], exp_q[k][10:8], exp_q[k][7:0]);
      end
      if (k > 0) begin
        tests_run++;
        if (obs_cyc_q[k] - obs_cyc_q[k-1] !== 2) begin
          tests_failed++;
          $display("FAIL all_four_gap[%0d]: got %0d cycles want 2", k, obs_cyc_q[k] - obs_cyc_q[k-1]);
        end
      end
    end
    tests_run++;
    if (hs_err !== 0) begin
      tests_failed++;
      $display("FAIL all_four_handshake: got %0d inconsistent cycles want 0", hs_err);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst      = 1'b1;
    tx_ready = 1'b1;
    drive_idle();
    test_reset();
    test_single_msg();
    test_two_req();
    test_backpressure();
    test_watchdog();
    test_mid_reset();
    test_all_four();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
